// File: rtl/validation_pkg.sv
// ============================================================================
//  Module      : validation_pkg
//  Description : Shared types for the validation scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package validation_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FOUND  = 2'd2
    } state_t;

    typedef logic [31:0]  nonce_t;
    typedef logic [255:0] hash_t;
    typedef logic [31:0]  difficulty_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter; one-hot grant, pointer moves past winner.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    localparam logic [ID_W:0]   c_num  = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] c_last = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W:0]   w_cand;

    // Scan requesters starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, r_ptr} + (ID_W+1)'(i);
            if (w_cand >= c_num) begin
                w_cand = w_cand - c_num;
            end
            if (!grant_valid && req[w_cand[ID_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = w_cand[ID_W-1:0];
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (grant_valid) begin
            r_ptr <= (grant_idx == c_last) ? '0 : grant_idx + ID_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/validation_scheduler.sv
// ============================================================================
//  Module      : validation_scheduler
//  Description : Shares one hash validator among NUM_CORES hashing cores and
//                holds the first winning nonce. Define
//                VALIDATION_SCHED_STATS_EN to build the hash_count_o counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module validation_scheduler
    import validation_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int CORE_ID_W = $clog2(NUM_CORES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   job_start_i,
    input  difficulty_t            job_difficulty_i,
    input  logic [NUM_CORES-1:0]   req_valid_i,
    input  hash_t [NUM_CORES-1:0]  req_hash_i,
    input  nonce_t [NUM_CORES-1:0] req_nonce_i,
    output logic [NUM_CORES-1:0]   req_ready_o,
    output hash_t                  val_hash_o,
    output difficulty_t            val_difficulty_o,
    input  logic                   val_success_i,
    output logic                   found_o,
    output nonce_t                 found_nonce_o,
    output logic [CORE_ID_W-1:0]   found_core_o,
    output logic                   busy_o,
    output logic [31:0]            hash_count_o
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_win;
    logic                   w_ready_en;
    logic [NUM_CORES-1:0]   w_req;
    logic [NUM_CORES-1:0]   w_grant;
    logic [CORE_ID_W-1:0]   w_grant_idx;
    logic                   w_grant_valid;
    logic                   w_qualified;

    logic                   r_inf_valid;
    nonce_t                 r_inf_nonce;
    logic [CORE_ID_W-1:0]   r_inf_core;

    difficulty_t            r_difficulty;
    logic                   r_found;
    nonce_t                 r_found_nonce;
    logic [CORE_ID_W-1:0]   r_found_core;

    // A job_start cycle never issues, so the in-flight slot empties on restart.
    assign w_ready_en  = (r_state == SEARCH) && !job_start_i;
    assign w_req       = req_valid_i & {NUM_CORES{w_ready_en}};
    assign w_qualified = val_success_i & r_inf_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_CORES),
        .ID_W    (CORE_ID_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (w_req),
        .grant       (w_grant),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    assign req_ready_o = w_grant;
    assign val_hash_o  = w_grant_valid ? req_hash_i[w_grant_idx] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_win        = 1'b0;
        case (r_state)
            IDLE: begin
                if (job_start_i) w_state_next = SEARCH;
            end
            SEARCH: begin
                if (job_start_i) begin
                    w_state_next = SEARCH;
                end else if (w_qualified) begin
                    w_state_next = FOUND;
                    w_win        = 1'b1;
                end
            end
            FOUND: begin
                if (job_start_i) w_state_next = SEARCH;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inf_valid <= 1'b0;
            r_inf_nonce <= '0;
            r_inf_core  <= '0;
        end else begin
            r_inf_valid <= w_grant_valid;
            if (w_grant_valid) begin
                r_inf_nonce <= req_nonce_i[w_grant_idx];
                r_inf_core  <= w_grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_difficulty  <= '0;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_found_core  <= '0;
        end else if (job_start_i) begin
            r_difficulty  <= job_difficulty_i;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_found_core  <= '0;
        end else if (w_win) begin
            r_found       <= 1'b1;
            r_found_nonce <= r_inf_nonce;
            r_found_core  <= r_inf_core;
        end
    end

    assign val_difficulty_o = r_difficulty;
    assign found_o          = r_found;
    assign found_nonce_o    = r_found_nonce;
    assign found_core_o     = r_found_core;
    assign busy_o           = (r_state == SEARCH);

`ifdef VALIDATION_SCHED_STATS_EN
    logic [31:0] r_hash_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hash_count <= '0;
        end else if (job_start_i) begin
            r_hash_count <= '0;
        end else if (w_grant_valid && !(&r_hash_count)) begin
            r_hash_count <= r_hash_count + 32'd1;
        end
    end

    assign hash_count_o = r_hash_count;
`else
    assign hash_count_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_validation_scheduler.sv
// ============================================================================
//  Module      : tb_validation_scheduler
//  Description : Directed scenarios plus random traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_validation_scheduler;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               job_start_i;
    logic [31:0]        job_difficulty_i;
    logic [N-1:0]       req_valid_i;
    logic [N-1:0][255:0] req_hash_i;
    logic [N-1:0][31:0] req_nonce_i;
    logic [N-1:0]       req_ready_o;
    logic [255:0]       val_hash_o;
    logic [31:0]        val_difficulty_o;
    logic               val_success_i;
    logic               found_o;
    logic [31:0]        found_nonce_o;
    logic [1:0]         found_core_o;
    logic               busy_o;
    logic [31:0]        hash_count_o;

    always #5 clk = ~clk;

    validation_scheduler #(.NUM_CORES(N)) dut (
        .clk              (clk),
        .rst              (rst),
        .job_start_i      (job_start_i),
        .job_difficulty_i (job_difficulty_i),
        .req_valid_i      (req_valid_i),
        .req_hash_i       (req_hash_i),
        .req_nonce_i      (req_nonce_i),
        .req_ready_o      (req_ready_o),
        .val_hash_o       (val_hash_o),
        .val_difficulty_o (val_difficulty_o),
        .val_success_i    (val_success_i),
        .found_o          (found_o),
        .found_nonce_o    (found_nonce_o),
        .found_core_o     (found_core_o),
        .busy_o           (busy_o),
        .hash_count_o     (hash_count_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: 0=idle, 1=search, 2=found
    int          m_state;
    int          m_ptr;
    bit          m_inf_v;
    logic [31:0] m_inf_nonce;
    int          m_inf_core;
    bit          m_found;
    logic [31:0] m_fnonce;
    int          m_fcore;
    logic [31:0] m_diff;
    logic [31:0] m_count;

    always @(negedge clk) begin : cmp
        int           g;
        logic [N-1:0] e_ready;
        logic [255:0] e_hash;
        logic [31:0]  e_cnt;
        if (!rst) begin
            m_state = 0; m_ptr = 0; m_inf_v = 0; m_inf_nonce = 0; m_inf_core = 0;
            m_found = 0; m_fnonce = 0; m_fcore = 0; m_diff = 0; m_count = 0;
            chk("rst_ready", req_ready_o, 0);
            chk("rst_vhash", val_hash_o, 0);
            chk("rst_vdiff", val_difficulty_o, 0);
            chk("rst_found", found_o, 0);
            chk("rst_fnonce", found_nonce_o, 0);
            chk("rst_fcore", found_core_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_count", hash_count_o, 0);
        end else begin
            g = -1;
            if (m_state == 1 && !job_start_i) begin
                for (int i = 0; i < N; i++) begin
                    if (g < 0 && req_valid_i[(m_ptr + i) % N]) g = (m_ptr + i) % N;
                end
            end
            e_ready = '0;
            e_hash  = '0;
            if (g >= 0) begin
                e_ready[g] = 1'b1;
                e_hash     = req_hash_i[g];
            end
`ifdef VALIDATION_SCHED_STATS_EN
            e_cnt = m_count;
`else
            e_cnt = 32'd0;
`endif
            chk("ready", req_ready_o, e_ready);
            chk("vhash", val_hash_o, e_hash);
            chk("vdiff", val_difficulty_o, m_diff);
            chk("found", found_o, m_found);
            chk("fnonce", found_nonce_o, m_fnonce);
            chk("fcore", found_core_o, m_fcore);
            chk("busy", busy_o, m_state == 1);
            chk("count", hash_count_o, e_cnt);
            if (job_start_i) begin
                m_state = 1; m_diff = job_difficulty_i; m_found = 0; m_fnonce = 0;
                m_fcore = 0; m_count = 0; m_inf_v = 0;
            end else begin
                if (m_state == 1 && val_success_i && m_inf_v) begin
                    m_found = 1; m_fnonce = m_inf_nonce; m_fcore = m_inf_core; m_state = 2;
                end
                m_inf_v = (g >= 0);
                if (g >= 0) begin
                    m_inf_nonce = req_nonce_i[g];
                    m_inf_core  = g;
                    m_ptr       = (g + 1) % N;
                    if (m_count != 32'hFFFF_FFFF) m_count++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            for (int w = 0; w < 8; w++) req_hash_i[i][w*32 +: 32] = $urandom;
            req_nonce_i[i] = $urandom;
        end
    endtask

    logic [N-1:0] rr_exp [5];
    logic [31:0]  exp_cnt5;

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`ifdef VALIDATION_SCHED_STATS_EN
        exp_cnt5 = 32'd5;
`else
        exp_cnt5 = 32'd0;
`endif
        job_start_i = 0; job_difficulty_i = 0; req_valid_i = 0; val_success_i = 0;
        rand_data();
        repeat (2) tick();
        rst = 1'b1;
        chk("lit_reset_found", found_o, 0);
        chk("lit_reset_busy", busy_o, 0);

        // Four cores all valid: round-robin sequence from pointer 0
        job_start_i = 1; job_difficulty_i = 32'h1234_5678;
        tick();
        job_start_i = 0; req_valid_i = 4'hF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("lit_rr_grant", req_ready_o, rr_exp[i]);
            tick();
        end
        req_valid_i = 0;
        chk("lit_rr_count", hash_count_o, exp_cnt5);
        chk("lit_rr_diff", val_difficulty_o, 32'h1234_5678);

        // Single core, winner on third issue; the issue alongside the verdict is dropped
        job_start_i = 1; job_difficulty_i = 32'h1d00_ffff;
        tick();
        job_start_i = 0; req_valid_i = 4'b0001;
        for (int n = 32'h28; n <= 32'h2A; n++) begin
            req_nonce_i[0] = n;
            tick();
        end
        req_nonce_i[0] = 32'h2B; val_success_i = 1;
        tick();
        chk("lit_win_found", found_o, 1);
        chk("lit_win_nonce", found_nonce_o, 32'h2A);
        chk("lit_win_core", found_core_o, 0);
        chk("lit_win_busy", busy_o, 0);
        #1;
        chk("lit_win_ready", req_ready_o, 0);
        tick();
        chk("lit_win_keep", found_nonce_o, 32'h2A);
        val_success_i = 0; req_valid_i = 0;

        // job_start beats a simultaneous qualified success
        job_start_i = 1; job_difficulty_i = 32'h1111_0000;
        tick();
        job_start_i = 0; req_valid_i = 4'b0100;
        tick();
        req_valid_i = 0; job_start_i = 1; job_difficulty_i = 32'hABCD_0001; val_success_i = 1;
        tick();
        job_start_i = 0; val_success_i = 0;
        chk("lit_prio_found", found_o, 0);
        chk("lit_prio_diff", val_difficulty_o, 32'hABCD_0001);
        chk("lit_prio_count", hash_count_o, 0);

        // Spurious verdict with nothing in flight
        val_success_i = 1;
        tick();
        val_success_i = 0;
        chk("lit_spur_found", found_o, 0);
        chk("lit_spur_busy", busy_o, 1);

        // Asynchronous reset with an issue in flight
        req_valid_i = 4'b0010;
        tick();
        req_valid_i = 0;
        #2 rst = 1'b0;
        #1;
        chk("lit_arst_busy", busy_o, 0);
        chk("lit_arst_diff", val_difficulty_o, 0);
        tick();
        rst = 1'b1; val_success_i = 1;
        tick();
        val_success_i = 0;
        chk("lit_arst_found", found_o, 0);
        chk("lit_arst_busy2", busy_o, 0);

        // Random traffic
        job_start_i = 1; job_difficulty_i = $urandom;
        tick();
        for (int c = 0; c < 3000; c++) begin
            job_start_i      = ($urandom % 20 == 0);
            job_difficulty_i = $urandom;
            req_valid_i      = N'($urandom);
            val_success_i    = ($urandom % 3 == 0);
            rand_data();
            tick();
        end
        job_start_i = 0; req_valid_i = 0; val_success_i = 0;
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/validation_scheduler.md
VALIDATION_SCHEDULER -- requirements
Module: validation_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of hashing-core requesters (2..16).
REQ-002 SHALL have parameter CORE_ID_W, default $clog2(NUM_CORES), width of core index.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port job_start_i  in  1  pulse: begin new search, load difficulty.
REQ-006 SHALL have port job_difficulty_i  in  32  compact difficulty word for the new job.
REQ-007 SHALL have port req_valid_i  in  NUM_CORES  per-core result valid.
REQ-008 SHALL have port req_hash_i  in  NUM_CORES x 256  per-core hash.
REQ-009 SHALL have port req_nonce_i  in  NUM_CORES x 32  per-core nonce.
REQ-010 SHALL have port req_ready_o  out  NUM_CORES  per-core accept; one-hot or zero.
REQ-011 SHALL have port val_hash_o  out  256  hash to shared validator.
REQ-012 SHALL have port val_difficulty_o  out  32  latched job difficulty to validator.
REQ-013 SHALL have port val_success_i  in  1  validator verdict, exactly 1 cycle after issue.
REQ-014 SHALL have port found_o  out  1  winning nonce held.
REQ-015 SHALL have port found_nonce_o  out  32  winning nonce.
REQ-016 SHALL have port found_core_o  out  CORE_ID_W  core that produced winner.
REQ-017 SHALL have port busy_o  out  1  high in SEARCH.
REQ-018 SHALL have port hash_count_o  out  32  hashes issued this job.

Function
REQ-019 SHALL implement states IDLE, SEARCH, FOUND; IDLE->SEARCH and FOUND->SEARCH and SEARCH->SEARCH on job_start_i; SEARCH->FOUND on qualified success.
REQ-020 SHALL, on job_start_i, latch job_difficulty_i into val_difficulty_o, clear found_o/found_nonce_o/found_core_o/hash_count_o, invalidate in-flight entry.
REQ-021 SHALL assert req_ready_o only in SEARCH and not on a job_start_i cycle; transfer = req_valid_i[k] & req_ready_o[k].
REQ-022 SHALL grant at most one core per cycle, round-robin: pointer moves to (winner+1) mod NUM_CORES after each grant; pointer unchanged with no grant.
REQ-023 SHALL drive val_hash_o = req_hash_i[granted] combinationally in the transfer cycle and record {nonce, core, valid} in a one-deep in-flight register.
REQ-024 SHALL qualify val_success_i with in-flight valid; unqualified val_success_i SHALL be ignored.
REQ-025 SHALL, on qualified success in SEARCH, latch in-flight nonce/core into found_nonce_o/found_core_o, set found_o, enter FOUND next cycle.
REQ-026 SHALL discard the result of a hash issued in the same cycle as a winning verdict; first winner is never overwritten.
REQ-027 SHALL give job_start_i priority over a simultaneous qualified success; that result is dropped.
REQ-028 SHALL increment hash_count_o by 1 per transfer, saturating at 0xFFFFFFFF.
REQ-029 SHALL hold found_* stable in FOUND until the next job_start_i.
REQ-030 SHALL drive busy_o = (state == SEARCH).

Reset
REQ-031 SHALL, while rst low, force state IDLE, pointer 0, in-flight invalid, and all outputs 0 (req_ready_o, val_hash_o, val_difficulty_o, found_o, found_nonce_o, found_core_o, busy_o, hash_count_o).
REQ-032 SHALL drop any in-flight verdict when reset asserts mid-search; operation resumes only on job_start_i.

Configuration
REQ-033 SHALL compile hash_count_o logic only when VALIDATION_SCHED_STATS_EN is defined; undefined, hash_count_o SHALL be constant 0 and no counter flops exist.

Structure
REQ-034 SHALL place state enum, nonce_t (32 bit), hash_t (256 bit), difficulty_t (32 bit) in package validation_pkg.
REQ-035 SHALL factor grant logic into sub-module rr_arbiter (req vector in, one-hot grant out, pointer advance).

Verification
REQ-036 Single core: job_start difficulty 0x1d00ffff, core0 valid, validator success on 3rd issue with nonce 0x2A -> found_o=1, found_nonce_o=0x2A, found_core_o=0, state FOUND, req_ready_o=0.
REQ-037 Four cores all valid, no success -> grants 0,1,2,3,0 on consecutive cycles; hash_count_o=5 after 5 cycles (STATS_EN).
REQ-038 Winner verdict in the same cycle as next issue -> second result ignored, found_nonce_o keeps first winner.
REQ-039 job_start_i coinciding with qualified success -> found_o stays 0, counters cleared, val_difficulty_o = new value.
REQ-040 Spurious val_success_i with no in-flight entry -> no state change.
REQ-041 rst low mid-SEARCH with issue in flight -> all outputs 0, IDLE; success pulse after release ignored.
